// File: rtl/spectrum_accumulator_if.sv
// Bus bundle for spectrum_accumulator: control, input sample stream and accumulated-spectrum output.
interface spectrum_accumulator_if #(
  parameter int ADDR_W = 10,
  parameter int DIN_W  = 24,
  parameter int ACC_W  = 32
);
  logic              acc_start;
  logic [7:0]        acc_num;
  logic [4:0]        num_bins;
  logic              spec_valid;
  logic [DIN_W-1:0]  spec_data;
  logic              spec_ready;
  logic [ACC_W-1:0]  D_out;
  logic [ADDR_W-1:0] D_addr;
  logic              data_valid_out;
  logic [4:0]        RangBin_counts;
  logic              busy;
  logic              done;

  modport master (
    output acc_start, acc_num, num_bins, spec_valid, spec_data,
    input  spec_ready, D_out, D_addr, data_valid_out, RangBin_counts, busy, done
  );

  modport slave (
    input  acc_start, acc_num, num_bins, spec_valid, spec_data,
    output spec_ready, D_out, D_addr, data_valid_out, RangBin_counts, busy, done
  );
endinterface

// File: rtl/spectrum_accumulator.sv
// Sums acc_num power spectra per range bin in a 2**ADDR_W x ACC_W RAM and streams each sum out.
// Build option: define SPEC_ACC_SAT_EN to clamp sums at 2**ACC_W-1 instead of wrapping.
module spectrum_accumulator #(
  parameter int ADDR_W = 10,
  parameter int DIN_W  = 24,
  parameter int ACC_W  = 32
) (
  input logic                 clk,
  input logic                 rst,
  spectrum_accumulator_if.slave bus
);
  localparam int NPTS = 2**ADDR_W;

  typedef enum logic [2:0] {S_IDLE, S_ACCUM, S_FLUSH, S_DUMP, S_DONE} state_t;
  state_t state, state_nxt;

  logic [ADDR_W-1:0] pnt;
  logic [7:0]        spc, last_spc;
  logic [4:0]        bin, last_bin;
  logic [ADDR_W:0]   dcnt;
  logic              xfer, last_xfer, dump_rd, dump_end;
  logic [ADDR_W-1:0] rd_addr;

  logic [ACC_W-1:0]  ram [NPTS];
  logic [ADDR_W-1:0] addr_p0, dmp_addr_p0;
  logic [DIN_W-1:0]  din_p0;
  logic              first_p0, acc_vld_p0, dmp_vld_p0;
  logic [ACC_W-1:0]  rd_data_p0;

  function automatic logic [ACC_W-1:0] acc_add(input logic [ACC_W-1:0] a,
                                               input logic [DIN_W-1:0] b);
`ifdef SPEC_ACC_SAT_EN
    logic [ACC_W:0] sum;
    sum = {1'b0, a} + (ACC_W+1)'(b);
    return sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
    return a + ACC_W'(b);
`endif
  endfunction

  assign xfer      = (state == S_ACCUM) && bus.spec_valid;
  assign last_xfer = xfer && (pnt == {ADDR_W{1'b1}}) && (spc == last_spc);
  assign dump_rd   = (state == S_DUMP) && !dcnt[ADDR_W];
  assign dump_end  = (state == S_DUMP) && dcnt[ADDR_W];
  assign rd_addr   = dump_rd ? dcnt[ADDR_W-1:0] : pnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.acc_start) state_nxt = S_ACCUM;
      S_ACCUM: if (last_xfer) state_nxt = S_FLUSH;
      S_FLUSH: state_nxt = S_DUMP;
      S_DUMP:  if (dump_end) state_nxt = (bin == last_bin) ? S_DONE : S_ACCUM;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.spec_ready = 1'b0;
    bus.busy       = 1'b0;
    bus.done       = 1'b0;
    case (state)
      S_IDLE:  ;
      S_ACCUM: begin bus.spec_ready = 1'b1; bus.busy = 1'b1; end
      S_DONE:  begin bus.done = 1'b1; bus.busy = 1'b1; end
      default: bus.busy = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pnt        <= '0;
      spc        <= '0;
      last_spc   <= '0;
      bin        <= '0;
      last_bin   <= '0;
      dcnt       <= '0;
      acc_vld_p0 <= 1'b0;
      dmp_vld_p0 <= 1'b0;
    end else begin
      acc_vld_p0 <= xfer;
      dmp_vld_p0 <= dump_rd;
      dcnt       <= (state == S_DUMP) ? dcnt + (ADDR_W+1)'(1) : '0;
      if (state == S_IDLE && bus.acc_start) begin
        last_spc <= (bus.acc_num == 8'd0) ? 8'd0 : bus.acc_num - 8'd1;
        last_bin <= (bus.num_bins == 5'd0) ? 5'd0 : bus.num_bins - 5'd1;
        bin      <= '0;
        pnt      <= '0;
        spc      <= '0;
      end
      if (xfer) begin
        pnt <= pnt + ADDR_W'(1);
        if (pnt == {ADDR_W{1'b1}}) spc <= spc + 8'd1;
      end
      if (dump_end && bin != last_bin) begin
        bin <= bin + 5'd1;
        pnt <= '0;
        spc <= '0;
      end
    end
  end

  // p0: sample captured alongside RAM read; the read-modify-write commits one cycle later
  always_ff @(posedge clk) begin
    if (xfer) begin
      addr_p0  <= pnt;
      din_p0   <= bus.spec_data;
      first_p0 <= (spc == 8'd0);
    end
    dmp_addr_p0 <= dcnt[ADDR_W-1:0];
    if (acc_vld_p0)
      ram[addr_p0] <= first_p0 ? ACC_W'(din_p0) : acc_add(rd_data_p0, din_p0);
    if (xfer || dump_rd)
      rd_data_p0 <= ram[rd_addr];
  end

  assign bus.data_valid_out = dmp_vld_p0;
  assign bus.D_out          = dmp_vld_p0 ? rd_data_p0 : '0;
  assign bus.D_addr         = dmp_vld_p0 ? dmp_addr_p0 : '0;
  assign bus.RangBin_counts = bin;
endmodule

// File: tb/tb_spectrum_accumulator.sv
// Directed bench for spectrum_accumulator: full-size instance plus a small 8-point instance for overflow.
module tb_spectrum_accumulator;
  localparam int NPTS = 1024;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spectrum_accumulator_if bus();
  spectrum_accumulator_if #(.ADDR_W(3), .DIN_W(24), .ACC_W(25)) sbus();

  spectrum_accumulator dut (.clk(clk), .rst(rst), .bus(bus.slave));
  spectrum_accumulator #(.ADDR_W(3), .DIN_W(24), .ACC_W(25)) sdut (.clk(clk), .rst(rst), .bus(sbus.slave));

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int last_xfer_cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor
  logic [31:0] mon_data [0:2047];
  logic [4:0]  mon_bin  [0:2047];
  int mon_n, mon_addr_err, mon_gap_err, mon_idle_err, mon_done, mon_first_cyc;
  logic mon_prev_vld;

  task automatic mon_clear();
    mon_n = 0; mon_addr_err = 0; mon_gap_err = 0; mon_idle_err = 0;
    mon_done = 0; mon_first_cyc = 0; mon_prev_vld = 1'b0;
  endtask

  always @(negedge clk) begin
    if (bus.data_valid_out) begin
      if (mon_n == 0) mon_first_cyc = cyc;
      if (bus.D_addr != 10'(mon_n % NPTS)) mon_addr_err++;
      if (mon_n < 2048) begin
        mon_data[mon_n] = bus.D_out;
        mon_bin[mon_n]  = bus.RangBin_counts;
      end
      mon_n++;
    end else begin
      if (bus.D_out != 0 || bus.D_addr != 0) mon_idle_err++;
      if (mon_prev_vld && (mon_n % NPTS) != 0) mon_gap_err++;
    end
    if (bus.done) mon_done++;
    mon_prev_vld = bus.data_valid_out;
  end

  function automatic logic [23:0] pattern(input int mode, input int s, input int p, input logic [23:0] c);
    case (mode)
      0:       return 24'(p);
      1:       return c;
      2:       return 24'(p + 1000 * s);
      default: return 24'(2 * p + 1);
    endcase
  endfunction

  function automatic logic [31:0] expected_sum(input int mode, input int i);
    case (mode)
      0:       return 32'(i);
      1:       return 32'd400;
      2:       return 32'(3 * i + 3000);
      3:       return 32'(2 * i + 1);
      default: return 32'd14;
    endcase
  endfunction

  task automatic start_run(input logic [7:0] n, input logic [4:0] b);
    @(negedge clk);
    bus.acc_num = n; bus.num_bins = b; bus.acc_start = 1'b1;
    @(negedge clk);
    bus.acc_start = 1'b0;
  endtask

  task automatic feed(input int nspec, input int mode, input logic [23:0] c, input bit gaps);
    int budget;
    bit acc;
    for (int s = 0; s < nspec; s++) begin
      for (int p = 0; p < NPTS; p++) begin
        if (gaps && $urandom_range(1, 0) == 1) begin
          bus.spec_valid = 1'b0;
          @(negedge clk);
        end
        budget = 0;
        forever begin
          bus.spec_valid = 1'b1;
          bus.spec_data  = pattern(mode, s, p, c);
          acc = bus.spec_ready;
          @(negedge clk);
          if (acc) break;
          budget++;
          if (budget > 5000) begin
            check_eq("feed_timeout", 64'(budget), 64'd0);
            bus.spec_valid = 1'b0;
            return;
          end
        end
        last_xfer_cyc = cyc;
      end
    end
    bus.spec_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int limit);
    int k = 0;
    while (!bus.done && k < limit) begin
      @(negedge clk);
      k++;
    end
    check_eq({tag, "_done_seen"}, 64'(bus.done), 64'd1);
    @(negedge clk);
  endtask

  task automatic verify_dump(input string tag, input int nbins, input int mode);
    int bad = 0;
    for (int k = 0; k < nbins * NPTS; k++)
      if (mon_data[k] !== expected_sum(mode, k % NPTS)) bad++;
    check_eq({tag, "_count"}, 64'(mon_n), 64'(nbins * NPTS));
    check_eq({tag, "_addr_order"}, 64'(mon_addr_err), 64'd0);
    check_eq({tag, "_gaps"}, 64'(mon_gap_err), 64'd0);
    check_eq({tag, "_idle_zero"}, 64'(mon_idle_err), 64'd0);
    check_eq({tag, "_first"}, 64'(mon_data[0]), 64'(expected_sum(mode, 0)));
    check_eq({tag, "_last"}, 64'(mon_data[NPTS-1]), 64'(expected_sum(mode, NPTS-1)));
    check_eq({tag, "_bad_points"}, 64'(bad), 64'd0);
    check_eq({tag, "_done_pulses"}, 64'(mon_done), 64'd1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [24:0] s_got [0:7];
  logic [24:0] s_exp_ovf;
  int s_n, k, budget;
  bit acc;

  initial begin
    bus.acc_start = 0; bus.acc_num = 0; bus.num_bins = 0; bus.spec_valid = 0; bus.spec_data = 0;
    sbus.acc_start = 0; sbus.acc_num = 0; sbus.num_bins = 0; sbus.spec_valid = 0; sbus.spec_data = 0;
    mon_clear();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_busy", 64'(bus.busy), 64'd0);
    check_eq("rst_ready", 64'(bus.spec_ready), 64'd0);
    check_eq("rst_valid", 64'(bus.data_valid_out), 64'd0);
    check_eq("rst_dout", 64'(bus.D_out), 64'd0);
    check_eq("rst_bin", 64'(bus.RangBin_counts), 64'd0);
    check_eq("rst_done", 64'(bus.done), 64'd0);

    // 1: single spectrum of point indices
    mon_clear();
    start_run(8'd1, 5'd1);
    check_eq("t1_busy", 64'(bus.busy), 64'd1);
    feed(1, 0, 24'd0, 1'b0);
    wait_done("t1", 3000);
    verify_dump("t1", 1, 0);
    check_eq("t1_latency", 64'(mon_first_cyc - last_xfer_cyc), 64'd2);
    check_eq("t1_idle_busy", 64'(bus.busy), 64'd0);

    // 2: four constant spectra, two bins
    mon_clear();
    start_run(8'd4, 5'd2);
    feed(8, 1, 24'd100, 1'b0);
    wait_done("t2", 3000);
    verify_dump("t2", 2, 1);
    check_eq("t2_bin0", 64'(mon_bin[0]), 64'd0);
    check_eq("t2_bin1", 64'(mon_bin[NPTS]), 64'd1);
    check_eq("t2_bin_hold", 64'(bus.RangBin_counts), 64'd1);

    // 3: three spectra with random bubbles
    mon_clear();
    start_run(8'd3, 5'd1);
    feed(3, 2, 24'd0, 1'b1);
    wait_done("t3", 3000);
    verify_dump("t3", 1, 2);

    // 5: zero counts behave as one; start during dump is ignored
    mon_clear();
    start_run(8'd0, 5'd0);
    feed(1, 3, 24'd0, 1'b0);
    k = 0;
    while (!bus.data_valid_out && k < 100) begin @(negedge clk); k++; end
    check_eq("t5_dump_seen", 64'(bus.data_valid_out), 64'd1);
    bus.acc_num = 8'd9; bus.num_bins = 5'd3; bus.acc_start = 1'b1;
    @(negedge clk);
    bus.acc_start = 1'b0;
    wait_done("t5", 3000);
    verify_dump("t5", 1, 3);
    repeat (5) @(negedge clk);
    check_eq("t5_no_restart_busy", 64'(bus.busy), 64'd0);
    check_eq("t5_no_restart_ready", 64'(bus.spec_ready), 64'd0);
    check_eq("t5_bin", 64'(bus.RangBin_counts), 64'd0);

    // 6: reset mid-dump of bin 1, then clean run
    mon_clear();
    start_run(8'd1, 5'd2);
    feed(2, 1, 24'd50, 1'b0);
    k = 0;
    while (!(bus.data_valid_out && bus.D_addr == 10'd500 && bus.RangBin_counts == 5'd1) && k < 5000) begin
      @(negedge clk);
      k++;
    end
    check_eq("t6_reach500", 64'(bus.D_addr), 64'd500);
    #1 rst = 1'b1;
    #1;
    check_eq("t6_rst_valid", 64'(bus.data_valid_out), 64'd0);
    check_eq("t6_rst_dout", 64'(bus.D_out), 64'd0);
    check_eq("t6_rst_daddr", 64'(bus.D_addr), 64'd0);
    check_eq("t6_rst_busy", 64'(bus.busy), 64'd0);
    check_eq("t6_rst_bin", 64'(bus.RangBin_counts), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    mon_clear();
    start_run(8'd2, 5'd1);
    feed(2, 1, 24'd7, 1'b0);
    wait_done("t6", 3000);
    verify_dump("t6", 1, 4);

    // 4: overflow on the 8-point instance (point 0 stays small)
`ifdef SPEC_ACC_SAT_EN
    s_exp_ovf = 25'h1FF_FFFF;
`else
    s_exp_ovf = 25'h1FF_FFFC;
`endif
    for (int i = 0; i < 8; i++) s_got[i] = '0;
    @(negedge clk);
    sbus.acc_num = 8'd4; sbus.num_bins = 5'd1; sbus.acc_start = 1'b1;
    @(negedge clk);
    sbus.acc_start = 1'b0;
    for (int s = 0; s < 4; s++)
      for (int p = 0; p < 8; p++) begin
        budget = 0;
        forever begin
          sbus.spec_valid = 1'b1;
          sbus.spec_data  = (p == 0) ? 24'd1 : 24'hFF_FFFF;
          acc = sbus.spec_ready;
          @(negedge clk);
          if (acc || budget > 100) break;
          budget++;
        end
      end
    sbus.spec_valid = 1'b0;
    s_n = 0;
    k = 0;
    while (!sbus.done && k < 100) begin
      if (sbus.data_valid_out) begin
        s_got[sbus.D_addr] = sbus.D_out;
        s_n++;
      end
      @(negedge clk);
      k++;
    end
    check_eq("t4_done_seen", 64'(sbus.done), 64'd1);
    check_eq("t4_count", 64'(s_n), 64'd8);
    check_eq("t4_pt0", 64'(s_got[0]), 64'd4);
    check_eq("t4_pt1", 64'(s_got[1]), 64'(s_exp_ovf));
    check_eq("t4_pt7", 64'(s_got[7]), 64'(s_exp_ovf));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
